// File: rtl/lap_recorder.sv
// lap_recorder: write side of the stopwatch lap memory.
// Captures time_in into one of DEPTH lap registers on each rising edge of the
// debounced lap button and exposes every register in parallel to the readout
// mux. Tracks the fill pointer, lap count, full and sticky overflow, and
// supports a single-cycle clear of the whole bank.
//
// Build option: define LAP_WRAP_EN for ring-buffer mode, where a capture while
// full overwrites the oldest lap. Left undefined, a capture while full is
// dropped. Overflow is set in both modes.
module lap_recorder #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic          rclk,
  input  logic          reset,
  input  logic [DW-1:0] time_in,
  input  logic          lap,
  input  logic          clr,
  output logic [DW-1:0] regQ0,
  output logic [DW-1:0] regQ1,
  output logic [DW-1:0] regQ2,
  output logic [DW-1:0] regQ3,
  output logic [DW-1:0] regQ4,
  output logic [DW-1:0] regQ5,
  output logic [DW-1:0] regQ6,
  output logic [DW-1:0] regQ7,
  output logic [DW-1:0] regQ8,
  output logic [DW-1:0] regQ9,
  output logic [DW-1:0] regQ10,
  output logic [DW-1:0] regQ11,
  output logic [DW-1:0] regQ12,
  output logic [DW-1:0] regQ13,
  output logic [DW-1:0] regQ14,
  output logic [DW-1:0] regQ15,
  output logic [3:0]    wr_addr,
  output logic [4:0]    lap_count,
  output logic          full,
  output logic          overflow
);

  logic [DW-1:0] lap_regs [DEPTH];
  logic          lap_q;
  logic          capture;

  // A capture is the first cycle lap is seen high after having been low.
  assign capture = lap & ~lap_q;

  // Full is a pure decode of the count, so it tracks lap_count with no delay.
  assign full = (lap_count == 5'(DEPTH));

  // Edge-detect register, lap bank, pointer, count and overflow.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would let wr_addr's new value leak
  // into the same-cycle write.
  always_ff @(posedge rclk) begin
    if (reset) begin
      // lap_q resets high so a button held through reset release is not a press.
      lap_q     <= 1'b1;
      wr_addr   <= '0;
      lap_count <= '0;
      overflow  <= 1'b0;
      // NOTE: the bank is reset (not left as uninitialised RAM) because all
      // sixteen registers are displayed in parallel and must read zero.
      for (int i = 0; i < DEPTH; i++) lap_regs[i] <= '0;
    end else begin
      lap_q <= lap;
      if (clr) begin
        // Clear wins over a coincident capture; that capture is discarded.
        wr_addr   <= '0;
        lap_count <= '0;
        overflow  <= 1'b0;
        for (int i = 0; i < DEPTH; i++) lap_regs[i] <= '0;
      end else if (capture) begin
        if (!full) begin
          lap_regs[wr_addr] <= time_in;
          wr_addr           <= wr_addr + 4'd1;
          lap_count         <= lap_count + 5'd1;
        end else begin
          overflow <= 1'b1;
`ifdef LAP_WRAP_EN
          // Ring buffer: overwrite the oldest lap; count stays saturated.
          lap_regs[wr_addr] <= time_in;
          wr_addr           <= wr_addr + 4'd1;
`endif
        end
      end
    end
  end

  assign regQ0  = lap_regs[0];
  assign regQ1  = lap_regs[1];
  assign regQ2  = lap_regs[2];
  assign regQ3  = lap_regs[3];
  assign regQ4  = lap_regs[4];
  assign regQ5  = lap_regs[5];
  assign regQ6  = lap_regs[6];
  assign regQ7  = lap_regs[7];
  assign regQ8  = lap_regs[8];
  assign regQ9  = lap_regs[9];
  assign regQ10 = lap_regs[10];
  assign regQ11 = lap_regs[11];
  assign regQ12 = lap_regs[12];
  assign regQ13 = lap_regs[13];
  assign regQ14 = lap_regs[14];
  assign regQ15 = lap_regs[15];

endmodule

// File: tb/tb_lap_recorder.sv
// tb_lap_recorder: directed table, hand-written corner sequences and random
// traffic for lap_recorder, all checked against a lap-list reference model.
module tb_lap_recorder;

  logic        rclk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] time_in = '0;
  logic        lap = 1'b1;
  logic        clr = 1'b0;
  logic [23:0] regQ0, regQ1, regQ2, regQ3, regQ4, regQ5, regQ6, regQ7;
  logic [23:0] regQ8, regQ9, regQ10, regQ11, regQ12, regQ13, regQ14, regQ15;
  logic [3:0]  wr_addr;
  logic [4:0]  lap_count;
  logic        full, overflow;

  int passed = 0;
  int total  = 0;

  lap_recorder dut (
    .rclk(rclk), .reset(reset), .time_in(time_in), .lap(lap), .clr(clr),
    .regQ0(regQ0), .regQ1(regQ1), .regQ2(regQ2), .regQ3(regQ3),
    .regQ4(regQ4), .regQ5(regQ5), .regQ6(regQ6), .regQ7(regQ7),
    .regQ8(regQ8), .regQ9(regQ9), .regQ10(regQ10), .regQ11(regQ11),
    .regQ12(regQ12), .regQ13(regQ13), .regQ14(regQ14), .regQ15(regQ15),
    .wr_addr(wr_addr), .lap_count(lap_count), .full(full), .overflow(overflow)
  );

  always #5 rclk = ~rclk;

  logic [23:0] q [16];
  assign q[0]  = regQ0;  assign q[1]  = regQ1;  assign q[2]  = regQ2;
  assign q[3]  = regQ3;  assign q[4]  = regQ4;  assign q[5]  = regQ5;
  assign q[6]  = regQ6;  assign q[7]  = regQ7;  assign q[8]  = regQ8;
  assign q[9]  = regQ9;  assign q[10] = regQ10; assign q[11] = regQ11;
  assign q[12] = regQ12; assign q[13] = regQ13; assign q[14] = regQ14;
  assign q[15] = regQ15;

`ifdef LAP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // Reference model: m_writes counts slot writes since the last clear/reset.
  // The next slot is m_writes mod 16, the count is min(m_writes, 16).
  logic [23:0] m_mem [16];
  int          m_writes;
  bit          m_prev;
  bit          m_ovf;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_writes = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit c, input bit l, input logic [23:0] t);
    bit press;
    if (r) begin
      model_clear();
      m_prev = 1'b1;
    end else begin
      press  = l && !m_prev;
      m_prev = l;
      if (c) model_clear();
      else if (press) begin
        if (m_writes >= 16) m_ovf = 1'b1;
        if (m_writes < 16 || WRAP) begin
          m_mem[m_writes % 16] = t;
          m_writes++;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_model();
    for (int i = 0; i < 16; i++) check($sformatf("model regQ%0d", i), 32'(q[i]), 32'(m_mem[i]));
    check("model wr_addr", 32'(wr_addr), 32'(m_writes % 16));
    check("model lap_count", 32'(lap_count), 32'((m_writes > 16) ? 16 : m_writes));
    check("model full", 32'(full), 32'(m_writes >= 16));
    check("model overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, sample at +1.
  task automatic cycle(input bit r, input bit c, input bit l, input logic [23:0] t);
    reset = r; clr = c; lap = l; time_in = t;
    @(posedge rclk);
    model_step(r, c, l, t);
    #1;
    check_model();
  endtask

  task automatic pulse(input logic [23:0] t);
    cycle(1'b0, 1'b0, 1'b0, t);
    cycle(1'b0, 1'b0, 1'b1, t);
  endtask

  typedef struct {
    bit          r, c, l;
    logic [23:0] t;
    logic [3:0]  e_addr;
    logic [4:0]  e_cnt;
    bit          e_ovf;
    logic [23:0] e_q0;
  } vec_t;

  vec_t vecs [18];

  initial begin
    model_clear();
    m_prev = 1'b1;

    // Reset with lap held, release with lap still high, then one press held 4 cycles.
    vecs[0]  = '{1, 0, 1, 24'h0,      0, 0, 0, 24'h0};
    vecs[1]  = '{1, 0, 1, 24'h0,      0, 0, 0, 24'h0};
    vecs[2]  = '{1, 0, 1, 24'h0,      0, 0, 0, 24'h0};
    vecs[3]  = '{0, 0, 1, 24'h111111, 0, 0, 0, 24'h0};
    vecs[4]  = '{0, 0, 1, 24'h222222, 0, 0, 0, 24'h0};
    vecs[5]  = '{0, 0, 1, 24'h333333, 0, 0, 0, 24'h0};
    vecs[6]  = '{0, 0, 1, 24'h444444, 0, 0, 0, 24'h0};
    vecs[7]  = '{0, 0, 1, 24'h555555, 0, 0, 0, 24'h0};
    vecs[8]  = '{0, 0, 0, 24'h012345, 0, 0, 0, 24'h0};
    vecs[9]  = '{0, 0, 1, 24'h012345, 1, 1, 0, 24'h012345};
    vecs[10] = '{0, 0, 1, 24'h777777, 1, 1, 0, 24'h012345};
    vecs[11] = '{0, 0, 1, 24'h888888, 1, 1, 0, 24'h012345};
    vecs[12] = '{0, 0, 1, 24'h999999, 1, 1, 0, 24'h012345};
    vecs[13] = '{0, 0, 0, 24'habcdef, 1, 1, 0, 24'h012345};
    vecs[14] = '{0, 0, 1, 24'habcdef, 2, 2, 0, 24'h012345};
    vecs[15] = '{0, 0, 0, 24'h0,      2, 2, 0, 24'h012345};
    vecs[16] = '{0, 1, 1, 24'h123123, 0, 0, 0, 24'h0};
    vecs[17] = '{0, 0, 1, 24'h456456, 0, 0, 0, 24'h0};

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].t);
      check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d lap_count", i), 32'(lap_count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d regQ0", i), 32'(regQ0), 32'(vecs[i].e_q0));
    end
    check("slot1 after clear", 32'(regQ1), 32'h0);

    // Fill to full: slot k holds k+1.
    for (int k = 0; k < 16; k++) pulse(24'(k + 1));
    for (int k = 0; k < 16; k++) check($sformatf("fill regQ%0d", k), 32'(q[k]), 32'(k + 1));
    check("fill lap_count", 32'(lap_count), 32'd16);
    check("fill full", 32'(full), 32'd1);
    check("fill wr_addr", 32'(wr_addr), 32'd0);
    check("fill overflow", 32'(overflow), 32'd0);

    // 17th capture while full.
    pulse(24'h999999);
    check("ovf overflow", 32'(overflow), 32'd1);
    check("ovf lap_count", 32'(lap_count), 32'd16);
`ifdef LAP_WRAP_EN
    check("ovf regQ0", 32'(regQ0), 32'h999999);
    check("ovf wr_addr", 32'(wr_addr), 32'd1);
`else
    check("ovf regQ0", 32'(regQ0), 32'h000001);
    check("ovf wr_addr", 32'(wr_addr), 32'd0);
`endif
    // Overflow is sticky while lap idles.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 24'h0);
    check("ovf sticky", 32'(overflow), 32'd1);

    // Clear coinciding with a press at lap_count = 5.
    cycle(1'b0, 1'b1, 1'b0, 24'h0);
    for (int k = 0; k < 5; k++) pulse(24'h050000 + 24'(k));
    check("pre-clr lap_count", 32'(lap_count), 32'd5);
    cycle(1'b0, 1'b0, 1'b0, 24'hdeadbe);
    cycle(1'b0, 1'b1, 1'b1, 24'hdeadbe);
    check("clr lap_count", 32'(lap_count), 32'd0);
    check("clr wr_addr", 32'(wr_addr), 32'd0);
    check("clr overflow", 32'(overflow), 32'd0);
    check("clr regQ0", 32'(regQ0), 32'd0);
    check("clr regQ4", 32'(regQ4), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 24'hdeadbe);
    check("clr held lap_count", 32'(lap_count), 32'd0);

    // Reset mid-fill after 7 captures.
    for (int k = 0; k < 7; k++) pulse(24'h070000 + 24'(k));
    check("mid lap_count", 32'(lap_count), 32'd7);
    cycle(1'b1, 1'b0, 1'b0, 24'h0);
    check("rst lap_count", 32'(lap_count), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst regQ6", 32'(regQ6), 32'd0);
    pulse(24'h000777);
    check("post-rst regQ0", 32'(regQ0), 32'h000777);
    check("post-rst lap_count", 32'(lap_count), 32'd1);

    // Random traffic: lap toggles often, clear and reset are rare.
    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 1) == 1), 24'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
